// File: rtl/aes_keyslot_ctrl.sv
// aes_keyslot_ctrl
//   Multi-context round-key store for the AES core. Holds NUM_SLOTS key
//   schedules. A short key is accepted into a slot, handed to the external
//   key expander, and the expanded round keys are captured into per-slot
//   memory. NUM_RD independent read ports (encrypt/decrypt engines) see a
//   per-round-key valid bit, so an engine may start before expansion ends.
//
//   Optional feature macro: AES_KEYSLOT_ZEROIZE_EN
//     defined   : invalidation also overwrites the slot's round keys with 0
//                 (one entry per cycle, state ZERO). Requests that arrive
//                 while zeroising are queued and serviced lowest slot first.
//     undefined : invalidation only clears valid bits; memory persists.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   key_wr_valid/rdy/slot       new-key handshake and target slot
//   key_len, short_key          01=128, 10=192, 11=256 (00 illegal); key MSB-aligned
//   exp_start/key/len           one-cycle start pulse and registered key/length
//   exp_rk_valid/addr/rk        expander round-key write strobe, index, data
//   exp_done                    expander finished
//   inval_valid, inval_slot     invalidate a slot (any state)
//   rd_slot, rd_addr            per-port slot/round-key select (packed)
//   rd_key, rd_hit              per-port registered round key and valid bit
//   slot_ready, slot_len        per-slot "schedule complete" and stored length
//   busy                        FSM not idle
//   error, err_clr              sticky error flag and its clear
module aes_keyslot_ctrl #(
  parameter int NUM_SLOTS = 4,
  parameter int NUM_RD    = 2,
  parameter int RK_W      = 128,
  parameter int MAX_RK    = 15,
  localparam int SW       = $clog2(NUM_SLOTS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key_wr_valid,
  output logic                   key_wr_rdy,
  input  logic [SW-1:0]          key_wr_slot,
  input  logic [1:0]             key_len,
  input  logic [255:0]           short_key,
  output logic                   exp_start,
  output logic [255:0]           exp_key,
  output logic [1:0]             exp_len,
  input  logic                   exp_rk_valid,
  input  logic [3:0]             exp_rk_addr,
  input  logic [RK_W-1:0]        exp_rk,
  input  logic                   exp_done,
  input  logic                   inval_valid,
  input  logic [SW-1:0]          inval_slot,
  input  logic [NUM_RD*SW-1:0]   rd_slot,
  input  logic [NUM_RD*4-1:0]    rd_addr,
  output logic [NUM_RD*RK_W-1:0] rd_key,
  output logic [NUM_RD-1:0]      rd_hit,
  output logic [NUM_SLOTS-1:0]   slot_ready,
  output logic [NUM_SLOTS*2-1:0] slot_len,
  output logic                   busy,
  output logic                   error,
  input  logic                   err_clr
);

`ifdef AES_KEYSLOT_ZEROIZE_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_FILL, S_DRAIN, S_ZERO} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_FILL, S_DRAIN} state_t;
`endif

  state_t state, state_nx;

  logic [SW-1:0]     cur_slot;
  logic [1:0]        cur_len;
  logic [RK_W-1:0]   mem   [NUM_SLOTS][MAX_RK];
  logic [MAX_RK-1:0] valid [NUM_SLOTS];

  logic              accept, accept_ok, filling, inval_fill;
  logic              fill_bad, fill_we, done_ok, done_all, err_set;
  logic [3:0]        nrk;
  logic [MAX_RK-1:0] nrk_mask, valid_after;

  // Shared memory write port (accept, fill and zeroise never overlap in time).
  logic              we;
  logic [SW-1:0]     wslot;
  logic [3:0]        waddr;
  logic [RK_W-1:0]   wdata;

  assign accept     = key_wr_valid && key_wr_rdy;
  assign accept_ok  = accept && (key_len != 2'b00);
  assign filling    = (state == S_START) || (state == S_FILL);
  // Invalidating the slot under expansion beats any same-cycle write to it.
  assign inval_fill = inval_valid && filling && (inval_slot == cur_slot);
  assign fill_bad   = (state == S_FILL) && exp_rk_valid &&
                      ((exp_rk_addr == 4'd0) || (exp_rk_addr >= nrk));
  assign fill_we    = (state == S_FILL) && exp_rk_valid && !fill_bad && !inval_fill;
  assign done_ok    = (state == S_FILL) && exp_done && !inval_fill;

  always_comb begin
    unique case (cur_len)
      2'b01:   nrk = 4'd11;
      2'b10:   nrk = 4'd13;
      default: nrk = 4'd15;
    endcase
    for (int i = 0; i < MAX_RK; i++) nrk_mask[i] = (4'(i) < nrk);
    // A write landing in the exp_done cycle counts toward completeness.
    valid_after = valid[cur_slot] | (fill_we ? (MAX_RK'(1) << exp_rk_addr) : '0);
    done_all    = &(valid_after | ~nrk_mask);
  end

  assign err_set = (accept && (key_len == 2'b00)) ||
                   ((state == S_IDLE) && exp_rk_valid) ||
                   fill_bad ||
                   (done_ok && !done_all);

`ifdef AES_KEYSLOT_ZEROIZE_EN
  logic [NUM_SLOTS-1:0] pend, pend_set;
  logic [SW-1:0]        zslot, znext;
  logic [3:0]           zaddr;
  logic                 zero_last, zero_go;

  function automatic logic [SW-1:0] lowest(input logic [NUM_SLOTS-1:0] m);
    lowest = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) if (m[i]) lowest = SW'(i);
  endfunction

  always_comb begin
    pend_set = pend;
    if (inval_valid) pend_set = pend_set | (NUM_SLOTS'(1) << inval_slot);
    // A same-cycle accept to the slot owns it; do not wipe the new key.
    if (accept_ok)   pend_set = pend_set & ~(NUM_SLOTS'(1) << key_wr_slot);
  end

  assign znext     = lowest(pend_set);
  assign zero_last = (zaddr == 4'(MAX_RK - 1));
  assign zero_go   = (pend_set != '0) &&
                     (((state == S_IDLE) && !accept_ok) ||
                      ((state == S_DRAIN) && exp_done) ||
                      ((state == S_ZERO) && zero_last));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend  <= '0;
      zslot <= '0;
      zaddr <= '0;
    end else if (zero_go) begin
      zslot <= znext;
      zaddr <= '0;
      pend  <= pend_set & ~(NUM_SLOTS'(1) << znext);
    end else begin
      pend  <= pend_set;
      if (state == S_ZERO) zaddr <= zaddr + 4'd1;
    end
  end
`endif

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking = here would make results depend on block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: default assignment first, so no path leaves state_nx unassigned
  // and no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept_ok) state_nx = S_START;
`ifdef AES_KEYSLOT_ZEROIZE_EN
        else if (pend_set != '0) state_nx = S_ZERO;
`endif
      end
      S_START: state_nx = inval_fill ? S_DRAIN : S_FILL;
      S_FILL: begin
        // If the invalidate coincides with exp_done there is nothing to drain.
        if (inval_fill)    state_nx = exp_done ? S_IDLE : S_DRAIN;
        else if (exp_done) state_nx = S_IDLE;
      end
      S_DRAIN: begin
`ifdef AES_KEYSLOT_ZEROIZE_EN
        if (exp_done) state_nx = (pend_set != '0) ? S_ZERO : S_IDLE;
`else
        if (exp_done) state_nx = S_IDLE;
`endif
      end
`ifdef AES_KEYSLOT_ZEROIZE_EN
      S_ZERO: if (zero_last && !zero_go) state_nx = S_IDLE;
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    key_wr_rdy = (state == S_IDLE);
    exp_start  = (state == S_START);
    busy       = (state != S_IDLE);
  end

  // ---------------- round-key memory ----------------
  always_comb begin
    we    = 1'b0;
    wslot = '0;
    waddr = '0;
    wdata = '0;
    if (accept_ok) begin
      we    = 1'b1;
      wslot = key_wr_slot;
      wdata = short_key[255 -: RK_W];
    end else if (fill_we) begin
      we    = 1'b1;
      wslot = cur_slot;
      waddr = exp_rk_addr;
      wdata = exp_rk;
    end
`ifdef AES_KEYSLOT_ZEROIZE_EN
    else if (state == S_ZERO) begin
      we    = 1'b1;
      wslot = zslot;
      waddr = zaddr;
    end
`endif
  end

  // NOTE: the key array has no reset; the valid bits alone define contents,
  // which keeps the array mappable onto RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wslot][waddr] <= wdata;
  end

  // ---------------- control / status registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_slot <= '0;
      cur_len  <= '0;
      exp_key  <= '0;
      exp_len  <= '0;
    end else if (accept_ok) begin
      cur_slot <= key_wr_slot;
      cur_len  <= key_len;
      exp_key  <= short_key;
      exp_len  <= key_len;
    end
  end

  // Per-slot priority: accept > invalidate > fill/done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_ready <= '0;
      slot_len   <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) valid[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (accept_ok && (key_wr_slot == SW'(s))) begin
          valid[s]          <= MAX_RK'(1);
          slot_ready[s]     <= 1'b0;
          slot_len[2*s +: 2] <= key_len;
        end else if (inval_valid && (inval_slot == SW'(s))) begin
          valid[s]          <= '0;
          slot_ready[s]     <= 1'b0;
          slot_len[2*s +: 2] <= 2'b00;
        end else if (cur_slot == SW'(s)) begin
          if (fill_we) valid[s][exp_rk_addr] <= 1'b1;
          if (done_ok) slot_ready[s]        <= done_all;
        end
      end
    end
  end

  // A new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        error <= 1'b0;
    else if (err_set) error <= 1'b1;
    else if (err_clr) error <= 1'b0;
  end

  // ---------------- read ports ----------------
  // Plain registered reads: a same-cycle write is not forwarded.
  logic [NUM_RD*RK_W-1:0] rd_key_d;
  logic [NUM_RD-1:0]      rd_hit_d;

  always_comb begin
    rd_key_d = '0;
    rd_hit_d = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (({1'b0, rd_slot[p*SW +: SW]} < (SW+1)'(NUM_SLOTS)) &&
          ({1'b0, rd_addr[p*4 +: 4]} < 5'(MAX_RK))) begin
        rd_key_d[p*RK_W +: RK_W] = mem[rd_slot[p*SW +: SW]][rd_addr[p*4 +: 4]];
        rd_hit_d[p]              = valid[rd_slot[p*SW +: SW]][rd_addr[p*4 +: 4]];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_key <= '0;
      rd_hit <= '0;
    end else begin
      rd_key <= rd_key_d;
      rd_hit <= rd_hit_d;
    end
  end

endmodule

// File: tb/tb_aes_keyslot_ctrl.sv
// Directed bench for aes_keyslot_ctrl (default parameters). Inputs change on
// the falling edge; outputs are sampled on the following falling edge.
module tb_aes_keyslot_ctrl;
  localparam int NUM_SLOTS = 4;
  localparam int NUM_RD    = 2;
  localparam int RK_W      = 128;
  localparam int MAX_RK    = 15;
  localparam int SW        = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   key_wr_valid, key_wr_rdy;
  logic [SW-1:0]          key_wr_slot;
  logic [1:0]             key_len;
  logic [255:0]           short_key;
  logic                   exp_start;
  logic [255:0]           exp_key;
  logic [1:0]             exp_len;
  logic                   exp_rk_valid;
  logic [3:0]             exp_rk_addr;
  logic [RK_W-1:0]        exp_rk;
  logic                   exp_done;
  logic                   inval_valid;
  logic [SW-1:0]          inval_slot;
  logic [NUM_RD*SW-1:0]   rd_slot;
  logic [NUM_RD*4-1:0]    rd_addr;
  logic [NUM_RD*RK_W-1:0] rd_key;
  logic [NUM_RD-1:0]      rd_hit;
  logic [NUM_SLOTS-1:0]   slot_ready;
  logic [NUM_SLOTS*2-1:0] slot_len;
  logic                   busy, error, err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  aes_keyslot_ctrl #(.NUM_SLOTS(NUM_SLOTS), .NUM_RD(NUM_RD), .RK_W(RK_W), .MAX_RK(MAX_RK)) dut (
    .clk(clk), .reset(reset),
    .key_wr_valid(key_wr_valid), .key_wr_rdy(key_wr_rdy), .key_wr_slot(key_wr_slot),
    .key_len(key_len), .short_key(short_key),
    .exp_start(exp_start), .exp_key(exp_key), .exp_len(exp_len),
    .exp_rk_valid(exp_rk_valid), .exp_rk_addr(exp_rk_addr), .exp_rk(exp_rk), .exp_done(exp_done),
    .inval_valid(inval_valid), .inval_slot(inval_slot),
    .rd_slot(rd_slot), .rd_addr(rd_addr), .rd_key(rd_key), .rd_hit(rd_hit),
    .slot_ready(slot_ready), .slot_len(slot_len), .busy(busy),
    .error(error), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Distinct, recognisable data for round key a of slot s.
  function automatic logic [127:0] rk_pat(input int s, input int a);
    logic [31:0] w;
    w = {8'hC0 + 8'(s), 8'h3C, 8'(a), 8'h5A};
    return {w, ~w, w ^ 32'h1234_5678, w + 32'd7};
  endfunction

  // Short key whose top half is round key 0 of the slot.
  function automatic logic [255:0] key_of(input int s);
    return {rk_pat(s, 0), ~rk_pat(s, 0)};
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic accept_key(input int s, input logic [1:0] len);
    key_wr_valid = 1'b1; key_wr_slot = SW'(s); key_len = len; short_key = key_of(s);
    cyc();
    key_wr_valid = 1'b0;
  endtask

  task automatic write_rk(input int s, input int a);
    exp_rk_valid = 1'b1; exp_rk_addr = 4'(a); exp_rk = rk_pat(s, a);
    cyc();
    exp_rk_valid = 1'b0;
  endtask

  task automatic finish_exp();
    exp_done = 1'b1;
    cyc();
    exp_done = 1'b0;
  endtask

  task automatic read2(input int s0, input int a0, input int s1, input int a1);
    rd_slot = {SW'(s1), SW'(s0)};
    rd_addr = {4'(a1), 4'(a0)};
    cyc();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 100) begin cyc(); k++; end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_idle: busy still %b", busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1; key_wr_valid = 0; key_wr_slot = 0; key_len = 0; short_key = 0;
    exp_rk_valid = 0; exp_rk_addr = 0; exp_rk = 0; exp_done = 0;
    inval_valid = 0; inval_slot = 0; rd_slot = 0; rd_addr = 0; err_clr = 0;
    cyc(); cyc();
    n_checks++; if (key_wr_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", key_wr_rdy); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
    n_checks++; if (slot_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", slot_ready); end
    n_checks++; if (slot_len !== 8'b0) begin n_fail++; $display("FAIL reset_len: got %b want 0", slot_len); end
    n_checks++; if (rd_hit !== 2'b0 || rd_key !== '0) begin n_fail++; $display("FAIL reset_rd: hit %b key %h want 0", rd_hit, rd_key); end
    n_checks++; if (exp_start !== 1'b0 || exp_key !== '0 || exp_len !== 2'b0) begin n_fail++; $display("FAIL reset_exp: start %b len %b key %h want 0", exp_start, exp_len, exp_key); end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_basic_fill();
    accept_key(2, 2'b01);
    n_checks++; if (exp_start !== 1'b1) begin n_fail++; $display("FAIL fill_start: got %b want 1", exp_start); end
    n_checks++; if (key_wr_rdy !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy: rdy %b busy %b want 0 1", key_wr_rdy, busy); end
    n_checks++; if (exp_key !== key_of(2) || exp_len !== 2'b01) begin n_fail++; $display("FAIL fill_expkey: len %b key %h", exp_len, exp_key); end
    cyc();
    n_checks++; if (exp_start !== 1'b0) begin n_fail++; $display("FAIL fill_start_pulse: got %b want 0", exp_start); end
    for (int a = 1; a <= 10; a++) write_rk(2, a);
    finish_exp();
    n_checks++; if (busy !== 1'b0 || key_wr_rdy !== 1'b1) begin n_fail++; $display("FAIL fill_done_idle: busy %b rdy %b", busy, key_wr_rdy); end
    n_checks++; if (slot_ready !== 4'b0100) begin n_fail++; $display("FAIL fill_ready: got %b want 0100", slot_ready); end
    n_checks++; if (slot_len[5:4] !== 2'b01) begin n_fail++; $display("FAIL fill_len: got %b want 01", slot_len[5:4]); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL fill_error: got %b want 0", error); end
    read2(2, 0, 2, 10);
    n_checks++; if (rd_key[127:0] !== rk_pat(2, 0) || rd_hit[0] !== 1'b1) begin n_fail++; $display("FAIL fill_rd0: hit %b key %h", rd_hit[0], rd_key[127:0]); end
    n_checks++; if (rd_key[255:128] !== rk_pat(2, 10) || rd_hit[1] !== 1'b1) begin n_fail++; $display("FAIL fill_rd10: hit %b key %h", rd_hit[1], rd_key[255:128]); end
  endtask

  task automatic test_read_during_fill();
    accept_key(0, 2'b11);
    cyc();
    read2(0, 5, 0, 5);
    n_checks++; if (rd_hit !== 2'b00) begin n_fail++; $display("FAIL early_hit: got %b want 00", rd_hit); end
    write_rk(0, 5);
    n_checks++; if (rd_hit[0] !== 1'b0) begin n_fail++; $display("FAIL no_forward: got %b want 0", rd_hit[0]); end
    cyc();
    n_checks++; if (rd_hit[0] !== 1'b1 || rd_key[127:0] !== rk_pat(0, 5)) begin n_fail++; $display("FAIL late_hit: hit %b key %h", rd_hit[0], rd_key[127:0]); end
    for (int a = 1; a <= 14; a++) if (a != 5) write_rk(0, a);
    finish_exp();
    n_checks++; if (slot_ready !== 4'b0101 || error !== 1'b0) begin n_fail++; $display("FAIL aes256_ready: ready %b error %b want 0101 0", slot_ready, error); end
    n_checks++; if (slot_len[1:0] !== 2'b11) begin n_fail++; $display("FAIL aes256_len: got %b want 11", slot_len[1:0]); end
  endtask

  task automatic test_errors();
    accept_key(3, 2'b10);
    cyc();
    for (int a = 1; a <= 11; a++) write_rk(3, a);
    finish_exp();
    n_checks++; if (slot_ready !== 4'b0101 || error !== 1'b1) begin n_fail++; $display("FAIL missing_rk: ready %b error %b want 0101 1", slot_ready, error); end
    cyc();
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", error); end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b want 0", error); end
    // Illegal length together with err_clr: new error wins, FSM stays idle.
    err_clr = 1'b1; accept_key(1, 2'b00); err_clr = 1'b0;
    n_checks++; if (error !== 1'b1 || busy !== 1'b0 || exp_start !== 1'b0) begin n_fail++; $display("FAIL bad_len: error %b busy %b start %b want 1 0 0", error, busy, exp_start); end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    write_rk(1, 3);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL idle_write: error %b want 1", error); end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    // Out-of-range (addr == NRK) and addr 0 writes are dropped with error.
    accept_key(1, 2'b01);
    cyc();
    write_rk(1, 11);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL addr_nrk: error %b want 1", error); end
    write_rk(3, 0);
    read2(1, 11, 1, 0);
    n_checks++; if (rd_hit[0] !== 1'b0) begin n_fail++; $display("FAIL addr_nrk_drop: hit %b want 0", rd_hit[0]); end
    n_checks++; if (rd_hit[1] !== 1'b1 || rd_key[255:128] !== rk_pat(1, 0)) begin n_fail++; $display("FAIL addr0_drop: hit %b key %h", rd_hit[1], rd_key[255:128]); end
    for (int a = 1; a <= 10; a++) write_rk(1, a);
    finish_exp();
    n_checks++; if (slot_ready !== 4'b0111 || error !== 1'b1) begin n_fail++; $display("FAIL addr_done: ready %b error %b want 0111 1", slot_ready, error); end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
  endtask

  task automatic test_inval_drain();
    accept_key(1, 2'b01);
    cyc();
    for (int a = 1; a <= 3; a++) write_rk(1, a);
    inval_valid = 1'b1; inval_slot = 2'd1;
    write_rk(1, 4);
    inval_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || key_wr_rdy !== 1'b0) begin n_fail++; $display("FAIL drain_busy: busy %b rdy %b want 1 0", busy, key_wr_rdy); end
    n_checks++; if (slot_ready[1] !== 1'b0 || slot_len[3:2] !== 2'b00) begin n_fail++; $display("FAIL drain_slot: ready %b len %b want 0 00", slot_ready[1], slot_len[3:2]); end
    for (int a = 5; a <= 7; a++) write_rk(1, a);
    finish_exp();
`ifdef AES_KEYSLOT_ZEROIZE_EN
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_zero: busy %b want 1", busy); end
    wait_idle();
`else
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle: busy %b want 0", busy); end
`endif
    n_checks++; if (error !== 1'b0 || slot_ready !== 4'b0101) begin n_fail++; $display("FAIL drain_end: error %b ready %b want 0 0101", error, slot_ready); end
    read2(1, 4, 1, 1);
    n_checks++; if (rd_hit !== 2'b00) begin n_fail++; $display("FAIL drain_rd: hit %b want 00", rd_hit); end
  endtask

  task automatic test_read_ports();
    read2(2, 3, 0, 7);
    n_checks++; if (rd_key[127:0] !== rk_pat(2, 3) || rd_key[255:128] !== rk_pat(0, 7) || rd_hit !== 2'b11) begin n_fail++; $display("FAIL ports_indep: hit %b key %h", rd_hit, rd_key); end
    read2(0, 0, 2, 15);
    n_checks++; if (rd_key[127:0] !== rk_pat(0, 0) || rd_hit[0] !== 1'b1) begin n_fail++; $display("FAIL port0_rk0: hit %b key %h", rd_hit[0], rd_key[127:0]); end
    n_checks++; if (rd_key[255:128] !== '0 || rd_hit[1] !== 1'b0) begin n_fail++; $display("FAIL port1_oor: hit %b key %h want 0 0", rd_hit[1], rd_key[255:128]); end
    read2(3, 12, 0, 14);
    n_checks++; if (rd_hit !== 2'b10 || rd_key[255:128] !== rk_pat(0, 14)) begin n_fail++; $display("FAIL ports_mixed: hit %b key %h want 10", rd_hit, rd_key[255:128]); end
  endtask

  task automatic test_invalidate();
    int busy_cnt;
    // Accept and invalidate of the same slot in one cycle: accept wins.
    inval_valid = 1'b1; inval_slot = 2'd3;
    accept_key(3, 2'b01);
    inval_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || slot_len[7:6] !== 2'b01) begin n_fail++; $display("FAIL accept_wins: busy %b len %b want 1 01", busy, slot_len[7:6]); end
    cyc();
    for (int a = 1; a <= 10; a++) write_rk(3, a);
    finish_exp();
    accept_key(1, 2'b01);
    cyc();
    for (int a = 1; a <= 10; a++) write_rk(1, a);
    finish_exp();
    n_checks++; if (slot_ready !== 4'b1111 || error !== 1'b0) begin n_fail++; $display("FAIL refill: ready %b error %b want 1111 0", slot_ready, error); end
    inval_valid = 1'b1; inval_slot = 2'd1;
    cyc();
    inval_valid = 1'b0;
`ifdef AES_KEYSLOT_ZEROIZE_EN
    busy_cnt = 0;
    for (int k = 0; k < 100 && busy; k++) begin
      busy_cnt++;
      if (k == 2) begin inval_valid = 1'b1; inval_slot = 2'd3; end
      cyc();
      inval_valid = 1'b0;
    end
    n_checks++; if (busy_cnt != 30) begin n_fail++; $display("FAIL zero_busy: %0d cycles want 30", busy_cnt); end
    n_checks++; if (slot_ready !== 4'b0101) begin n_fail++; $display("FAIL zero_ready: got %b want 0101", slot_ready); end
    for (int a = 0; a < MAX_RK; a++) begin
      read2(1, a, 3, a);
      n_checks++; if (rd_key !== '0 || rd_hit !== 2'b00) begin n_fail++; $display("FAIL zero_rd addr %0d: hit %b key %h want 0", a, rd_hit, rd_key); end
    end
`else
    busy_cnt = 0;
    n_checks++; if (busy !== 1'b0 || slot_ready !== 4'b1101) begin n_fail++; $display("FAIL inval_fast: busy %b ready %b want 0 1101", busy, slot_ready); end
    inval_valid = 1'b1; inval_slot = 2'd3;
    cyc();
    inval_valid = 1'b0;
    n_checks++; if (slot_ready !== 4'b0101 || slot_len[7:6] !== 2'b00) begin n_fail++; $display("FAIL inval_slot3: ready %b len %b", slot_ready, slot_len[7:6]); end
    for (int a = 0; a <= 10; a++) begin
      read2(1, a, 3, a);
      n_checks++; if (rd_hit !== 2'b00 || rd_key[127:0] !== rk_pat(1, a) || rd_key[255:128] !== rk_pat(3, a)) begin n_fail++; $display("FAIL inval_rd addr %0d: hit %b key %h", a, rd_hit, rd_key); end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_read_during_fill();
    test_errors();
    test_inval_drain();
    test_read_ports();
    test_invalidate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
